// File: rtl/shift_pkg.sv
// Shared constants and encodings for the shift arbiter slice.
// Optional feature macro: SHIFT_ARB_SRL_EN (enables the logical right shift op).
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_SRL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/shift_core.sv
// Purely combinational 32-bit shifter: five staged 2:1 mux layers per direction.
// Optional feature macro: SHIFT_ARB_SRL_EN (zero-fill right shift for op 2'b10).
module shift_core
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [1:0]         op_i,
  output logic [DATA_W-1:0]  result_o
);

  logic [SHAMT_W:0][DATA_W-1:0] left_s;
  logic [SHAMT_W:0][DATA_W-1:0] right_s;
  logic                         fill;

  // Right-shift fill bit: sign for SRA, zero for SRL when that op exists.
  always_comb begin
    fill = data_i[DATA_W-1];
`ifdef SHIFT_ARB_SRL_EN
    if (op_i == OP_SRL) fill = 1'b0;
`endif
  end

  assign left_s[0]  = data_i;
  assign right_s[0] = data_i;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int S = 1 << k;
    assign left_s[k+1]  = shamt_i[k] ? {left_s[k][DATA_W-1-S:0], {S{1'b0}}} : left_s[k];
    assign right_s[k+1] = shamt_i[k] ? {{S{fill}}, right_s[k][DATA_W-1:S]}  : right_s[k];
  end

  // Select the direction by op; undefined ops return zero.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_SLL:  result_o = left_s[SHAMT_W];
      OP_SRA:  result_o = right_s[SHAMT_W];
`ifdef SHIFT_ARB_SRL_EN
      OP_SRL:  result_o = right_s[SHAMT_W];
`endif
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a shared combinational shifter.
// IDLE accepts, EXEC runs the captured operands through shift_core, HOLD
// presents the registered result until the consumer takes it.
// Optional feature macro: SHIFT_ARB_SRL_EN (passed through to shift_core).
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high. reqN_ready is combinational, only asserted for the granted valid
// requester while idle or while the held result is being retired; requesters
// keep valid/data stable until that transfer. resp_valid stays high with
// resp_data/resp_id frozen until resp_ready is seen.
module shift_arbiter
  import shift_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]         req1_op,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_data,
  output logic               resp_id,
  output logic [1:0]         dbg_state
);

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [DATA_W-1:0]  cap_data_q, cap_data_d;
  logic [SHAMT_W-1:0] cap_shamt_q, cap_shamt_d;
  logic [1:0]         cap_op_q, cap_op_d;
  logic               cap_id_q, cap_id_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic               resp_id_q, resp_id_d;

  logic               any_valid;
  logic               grant_id;
  logic               window;
  logic               accept;
  logic [DATA_W-1:0]  core_result;

  shift_core u_core (
    .data_i   (cap_data_q),
    .shamt_i  (cap_shamt_q),
    .op_i     (cap_op_q),
    .result_o (core_result)
  );

  // Round-robin pick and the accept window; nothing is granted during reset.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant_q;
    else                          grant_id = req1_valid;
    window     = !reset && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && resp_ready));
    accept     = window && any_valid;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  // Next-state, capture and result-register update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cap_data_d   = cap_data_q;
    cap_shamt_d  = cap_shamt_q;
    cap_op_d     = cap_op_q;
    cap_id_d     = cap_id_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;

    if (accept) begin
      last_grant_d = grant_id;
      cap_id_d     = grant_id;
      cap_data_d   = grant_id ? req1_data  : req0_data;
      cap_shamt_d  = grant_id ? req1_shamt : req0_shamt;
      cap_op_d     = grant_id ? req1_op    : req0_op;
    end

    case (state_q)
      ST_IDLE: if (any_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        state_d     = ST_HOLD;
        resp_data_d = core_result;
        resp_id_d   = cap_id_q;
      end
      ST_HOLD: if (resp_ready) state_d = any_valid ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers; reset drops any in-flight transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cap_data_q   <= '0;
      cap_shamt_q  <= '0;
      cap_op_q     <= '0;
      cap_id_q     <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cap_data_q   <= cap_data_d;
      cap_shamt_q  <= cap_shamt_d;
      cap_op_q     <= cap_op_d;
      cap_id_q     <= cap_id_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign resp_valid = (state_q == ST_HOLD);
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios followed by random traffic,
// checked cycle by cycle against a transaction-level reference model.
// Build with +define+SHIFT_ARB_SRL_EN to exercise the optional SRL op.
module tb_shift_arbiter;
  import shift_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_data;
  logic [1:0]  dbg_state;

  shift_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_op    (req1_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .dbg_state  (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'b00:   r = d << s;
      2'b01:   r = $signed(d) >>> s;
`ifdef SHIFT_ARB_SRL_EN
      2'b10:   r = d >> s;
`else
      2'b10:   r = 32'h0;
`endif
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic        exp_id_q[$];
  int          due_q[$];
  logic [31:0] model_rd;
  logic        model_rid;
  logic        model_last;
  logic        m_busy, m_rv, m_win, m_wv, m_wid;
  int          retired = 0;

  // Monitor: mid-cycle, predict handshake outputs and compare the held result.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
      chk("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
      exp_q.delete();
      exp_id_q.delete();
      due_q.delete();
      model_rd   = 32'h0;
      model_rid  = 1'b0;
      model_last = 1'b1;
    end else begin
      m_busy = (exp_q.size() != 0);
      if (m_busy && cyc == due_q[0]) begin
        model_rd  = exp_q[0];
        model_rid = exp_id_q[0];
      end
      m_rv = m_busy && (cyc >= due_q[0]);
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_rv});
      chk("resp_data",  resp_data, model_rd);
      chk("resp_id",    {31'b0, resp_id}, {31'b0, model_rid});
      if (!m_busy) chk("state_idle", {30'b0, dbg_state}, {30'b0, ST_IDLE});
      m_win = !m_busy || (m_rv && resp_ready);
      m_wv  = req0_valid || req1_valid;
      m_wid = (req0_valid && req1_valid) ? !model_last : req1_valid;
      chk("req0_ready", {31'b0, req0_ready}, {31'b0, m_win && m_wv && !m_wid});
      chk("req1_ready", {31'b0, req1_ready}, {31'b0, m_win && m_wv && m_wid});
      if (m_rv && resp_ready) begin
        void'(exp_q.pop_front());
        void'(exp_id_q.pop_front());
        void'(due_q.pop_front());
        retired++;
      end
      if (m_win && m_wv) begin
        exp_q.push_back(m_wid ? ref_shift(req1_data, req1_shamt, req1_op)
                              : ref_shift(req0_data, req0_shamt, req0_op));
        exp_id_q.push_back(m_wid);
        due_q.push_back(cyc + 2);
        model_last = m_wid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int r, input logic v, input logic [31:0] d,
                         input logic [4:0] s, input logic [1:0] op);
    if (r == 0) begin
      req0_valid = v; req0_data = d; req0_shamt = s; req0_op = op;
    end else begin
      req1_valid = v; req1_data = d; req1_shamt = s; req1_op = op;
    end
  endtask

  // Present one request, wait up to max_hold cycles for the transfer, then drop valid.
  task automatic drive_req(input int r, input logic [31:0] d, input logic [4:0] s,
                           input logic [1:0] op, input int max_hold, input bit must_accept);
    bit acc = 0;
    set_req(r, 1'b1, d, s, op);
    for (int i = 0; i < max_hold; i++) begin
      @(negedge clock);
      if ((r == 0) ? req0_ready : req1_ready) begin
        acc = 1;
        break;
      end
    end
    @(posedge clock); #1;
    set_req(r, 1'b0, $urandom, 5'($urandom), 2'($urandom));
    if (must_accept) begin
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL accept_timeout: requester %0d not accepted within %0d cycles", r, max_hold);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic rand_req(input int r, input int n);
    bit wd;
    for (int t = 0; t < n; t++) begin
      idle($urandom_range(0, 3));
      wd = ($urandom_range(0, 7) == 0);
      drive_req(r, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                wd ? 1 : 300, !wd);
    end
  endtask

  // ---------------- stimulus ----------------
  bit rand_done = 0;

  initial begin
    set_req(0, 1'b0, 32'h0, 5'd0, 2'd0);
    set_req(1, 1'b0, 32'h0, 5'd0, 2'd0);
    resp_ready = 1'b1;
    reset      = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);

    // Single requests: SRA, SLL, shamt 0 pass-through, reserved op.
    drive_req(0, 32'h8000_0000, 5'd4,  2'b01, 20, 1); idle(3);
    drive_req(1, 32'h0000_0001, 5'd31, 2'b00, 20, 1); idle(3);
    drive_req(0, 32'hDEAD_BEEF, 5'd0,  2'b00, 20, 1); idle(3);
    drive_req(1, 32'hDEAD_BEEF, 5'd0,  2'b01, 20, 1); idle(3);
    drive_req(0, 32'hDEAD_BEEF, 5'd7,  2'b11, 20, 1); idle(3);

    // Tie from reset state: alternating grants while both stay valid.
    set_req(0, 1'b1, 32'h1234_5678, 5'd3, 2'b00);
    set_req(1, 1'b1, 32'hF000_000F, 5'd5, 2'b01);
    idle(12);
    set_req(0, 1'b0, 32'h0, 5'd0, 2'd0);
    set_req(1, 1'b0, 32'h0, 5'd0, 2'd0);
    idle(4);

    // Backpressure: hold the result, then retire it and accept req1 together.
    resp_ready = 1'b0;
    drive_req(0, 32'hA5A5_0001, 5'd8, 2'b01, 20, 1);
    set_req(1, 1'b1, 32'h0F0F_F0F0, 5'd12, 2'b00);
    idle(6);
    resp_ready = 1'b1;
    drive_req(1, 32'h0F0F_F0F0, 5'd12, 2'b00, 5, 1);
    idle(4);

    // Reset while the captured request is in EXEC.
    drive_req(1, 32'h7777_7777, 5'd1, 2'b00, 20, 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(2);
    set_req(0, 1'b1, 32'h8000_0001, 5'd2, 2'b01);
    set_req(1, 1'b1, 32'h8000_0001, 5'd2, 2'b00);
    idle(4);
    set_req(0, 1'b0, 32'h0, 5'd0, 2'd0);
    set_req(1, 1'b0, 32'h0, 5'd0, 2'd0);
    idle(4);

    // Optional SRL op (reserved when the feature is off).
    drive_req(0, 32'h8000_0000, 5'd4, 2'b10, 20, 1); idle(4);

    // Random traffic from both requesters with random backpressure.
    fork
      begin
        while (!rand_done) begin
          @(posedge clock); #1;
          resp_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        fork
          rand_req(0, 60);
          rand_req(1, 60);
        join
        rand_done = 1;
      end
    join
    resp_ready = 1'b1;
    idle(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses never seen, expected 0", exp_q.size());
    end
    checks++;
    if (retired < 20) begin
      errors++;
      $display("FAIL retired_count: got %0d responses, expected at least 20", retired);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
